// File: rtl/memory_inhibit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : memory_inhibit_sequencer
// Description : Core-memory write-back sequencer. Latches one duplex side of
//               buffer-register bits and times the inhibit and write-current
//               drivers of the addressed module.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_inhibit_sequencer #(
    parameter int T_SETUP   = 2,
    parameter int T_WRITE   = 4,
    parameter int T_RECOVER = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       WRST,
    input  logic       WABT,
    input  logic [2:0] MSEL,
    input  logic       BRA6,
    input  logic       BRA9,
    input  logic       BRA12,
    input  logic       BRA14,
    input  logic       BRB6,
    input  logic       BRB9,
    input  logic       BRB12,
    input  logic       BRB14,
    output logic [7:0] ID6,
    output logic [7:0] ID9,
    output logic [7:0] ID12,
    output logic [7:0] ID14,
    output logic [7:0] WRCUR,
    output logic       BUSY,
    output logic       WDONE
);

    localparam int c_cnt_w = 8;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_inhib   = 2'd1;
    localparam logic [1:0] c_st_write   = 2'd2;
    localparam logic [1:0] c_st_recover = 2'd3;

    localparam logic [c_cnt_w-1:0] c_ld_setup   = c_cnt_w'(T_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_ld_write   = c_cnt_w'(T_WRITE - 1);
    localparam logic [c_cnt_w-1:0] c_ld_recover = c_cnt_w'(T_RECOVER - 1);

    logic [1:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2:0]         msel_q, msel_d;
    logic [3:0]         bits_q, bits_d;   // {b14, b12, b9, b6}
    logic [7:0]         id6_q, id6_d, id9_q, id9_d, id12_q, id12_d, id14_q, id14_d;
    logic [7:0]         wrcur_q, wrcur_d;
    logic               busy_q, busy_d;
    logic               wdone_q, wdone_d;
    logic [7:0]         w_sel;

    // State register, including the registered copies of every output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            msel_q  <= '0;
            bits_q  <= '0;
            id6_q   <= '0;
            id9_q   <= '0;
            id12_q  <= '0;
            id14_q  <= '0;
            wrcur_q <= '0;
            busy_q  <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msel_q  <= msel_d;
            bits_q  <= bits_d;
            id6_q   <= id6_d;
            id9_q   <= id9_d;
            id12_q  <= id12_d;
            id14_q  <= id14_d;
            wrcur_q <= wrcur_d;
            busy_q  <= busy_d;
            wdone_q <= wdone_d;
        end
    end

    // Next-state logic; abort takes priority over phase expiry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msel_d  = msel_q;
        bits_d  = bits_q;
        case (state_q)
            c_st_idle: begin
                if (WRST) begin
                    msel_d  = MSEL;
                    bits_d  = MSEL[0] ? {BRB14, BRB12, BRB9, BRB6}
                                      : {BRA14, BRA12, BRA9, BRA6};
                    state_d = c_st_inhib;
                    cnt_d   = c_ld_setup;
                end
            end
            c_st_inhib: begin
                if (WABT) begin
                    state_d = c_st_recover;
                    cnt_d   = c_ld_recover;
                end else if (cnt_q == '0) begin
                    state_d = c_st_write;
                    cnt_d   = c_ld_write;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            c_st_write: begin
                if (WABT || (cnt_q == '0)) begin
                    state_d = c_st_recover;
                    cnt_d   = c_ld_recover;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            c_st_recover: begin
                if (cnt_q == '0) begin
                    state_d = c_st_idle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = c_st_idle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear on the same edge
    always_comb begin
        w_sel   = 8'b1 << msel_d;
        busy_d  = (state_d != c_st_idle);
        id6_d   = (busy_d && !bits_d[0]) ? w_sel : 8'h00;
        id9_d   = (busy_d && !bits_d[1]) ? w_sel : 8'h00;
        id12_d  = (busy_d && !bits_d[2]) ? w_sel : 8'h00;
        id14_d  = (busy_d && !bits_d[3]) ? w_sel : 8'h00;
        wrcur_d = (state_d == c_st_write) ? w_sel : 8'h00;
        wdone_d = (state_q == c_st_recover) && (state_d == c_st_idle);
    end

    assign ID6   = id6_q;
    assign ID9   = id9_q;
    assign ID12  = id12_q;
    assign ID14  = id14_q;
    assign WRCUR = wrcur_q;
    assign BUSY  = busy_q;
    assign WDONE = wdone_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_inhibit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_inhibit_sequencer
// Description : Scoreboard bench for memory_inhibit_sequencer (default and
//               minimum-timing instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_inhibit_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       WRST = 1'b0, WRST_F = 1'b0, WABT = 1'b0;
    logic [2:0] MSEL = 3'd0;
    logic       BRA6 = 0, BRA9 = 0, BRA12 = 0, BRA14 = 0;
    logic       BRB6 = 0, BRB9 = 0, BRB12 = 0, BRB14 = 0;
    logic [7:0] ID6, ID9, ID12, ID14, WRCUR;
    logic       BUSY, WDONE;
    logic [7:0] F_ID6, F_ID9, F_ID12, F_ID14, F_WRCUR;
    logic       F_BUSY, F_WDONE;

    always #5 clk = ~clk;

    memory_inhibit_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .WRST(WRST), .WABT(WABT), .MSEL(MSEL),
        .BRA6(BRA6), .BRA9(BRA9), .BRA12(BRA12), .BRA14(BRA14),
        .BRB6(BRB6), .BRB9(BRB9), .BRB12(BRB12), .BRB14(BRB14),
        .ID6(ID6), .ID9(ID9), .ID12(ID12), .ID14(ID14),
        .WRCUR(WRCUR), .BUSY(BUSY), .WDONE(WDONE)
    );

    memory_inhibit_sequencer #(.T_SETUP(1), .T_WRITE(1), .T_RECOVER(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .WRST(WRST_F), .WABT(WABT), .MSEL(MSEL),
        .BRA6(BRA6), .BRA9(BRA9), .BRA12(BRA12), .BRA14(BRA14),
        .BRB6(BRB6), .BRB9(BRB9), .BRB12(BRB12), .BRB14(BRB14),
        .ID6(F_ID6), .ID9(F_ID9), .ID12(F_ID12), .ID14(F_ID14),
        .WRCUR(F_WRCUR), .BUSY(F_BUSY), .WDONE(F_WDONE)
    );

    typedef struct {
        logic [7:0] id6, id9, id12, id14, wr;
        int         busy_len, wr_len, wr_first;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   idle_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] i6, i9, i12, i14, wr,
                        input int bl, wl, wf);
        exp_t e;
        e.id6 = i6; e.id9 = i9; e.id12 = i12; e.id14 = i14; e.wr = wr;
        e.busy_len = bl; e.wr_len = wl; e.wr_first = wf;
        exp_q.push_back(e);
    endtask

    // a = {b6, b9, b12, b14} for side A, b likewise for side B
    task automatic start(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
        MSEL = m;
        {BRA6, BRA9, BRA12, BRA14} = a;
        {BRB6, BRB9, BRB12, BRB14} = b;
        WRST = 1'b1;
        @(posedge clk); #1;
        WRST = 1'b0;
        MSEL = ~m;
        {BRA6, BRA9, BRA12, BRA14} = ~a;
        {BRB6, BRB9, BRB12, BRB14} = ~b;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (WDONE) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Monitor: gathers per-sequence observations, compares when WDONE appears
    exp_t cur;
    logic in_seq = 1'b0;
    int   bcnt, wcnt, wfirst, idbad, wbad;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_seq = 1'b0;
        end else begin
            if (BUSY) begin
                if (!in_seq) begin
                    in_seq = 1'b1;
                    bcnt = 0; wcnt = 0; wfirst = 0; idbad = 0; wbad = 0;
                    if (exp_q.size() > 0) cur = exp_q[0];
                end
                bcnt++;
                if ({ID6, ID9, ID12, ID14} !== {cur.id6, cur.id9, cur.id12, cur.id14})
                    idbad++;
                if (WRCUR !== 8'h00) begin
                    if (WRCUR !== cur.wr) wbad++;
                    if (wcnt == 0) wfirst = bcnt;
                    wcnt++;
                end
            end else if ({ID6, ID9, ID12, ID14, WRCUR} !== 40'h0) begin
                idle_bad++;
            end
            if (WDONE) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wdone", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("busy_len",   bcnt,   e.busy_len);
                    chk("wrcur_len",  wcnt,   e.wr_len);
                    chk("wrcur_first", wfirst, e.wr_first);
                    chk("inhibit_bad_cycles", idbad, 0);
                    chk("wrcur_bad_cycles",   wbad,  0);
                end
                chk("busy_at_wdone", BUSY, 1'b0);
                in_seq = 1'b0;
            end
        end
    end

    initial begin
        logic saw;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_id", {ID6, ID9, ID12, ID14}, 32'h0);
        chk("rst_wrcur_busy_wdone", {WRCUR, BUSY, WDONE}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Even module, side A
        push(8'h00, 8'h04, 8'h00, 8'h04, 8'h04, 8, 4, 3);
        start(3'd2, 4'b1010, 4'b0101);
        wait_done("t1");
        repeat (2) @(posedge clk); #1;

        // Odd module, side B, all zeros inhibit every plane
        push(8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8, 4, 3);
        start(3'd5, 4'b0000, 4'b0000);
        wait_done("t2");
        @(posedge clk); #1;

        // Abort on the second write cycle
        push(8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 6, 2, 3);
        start(3'd1, 4'b0000, 4'b1101);
        repeat (3) @(posedge clk);
        #1 WABT = 1'b1;
        @(posedge clk); #1 WABT = 1'b0;
        wait_done("t3");
        @(posedge clk); #1;

        // WRST while busy is ignored; back-to-back start on WDONE
        push(8'h04, 8'h00, 8'h00, 8'h04, 8'h04, 8, 4, 3);
        start(3'd2, 4'b0110, 4'b0000);
        @(posedge clk); #1;
        MSEL = 3'd7; {BRB6, BRB9, BRB12, BRB14} = 4'b0000; WRST = 1'b1;
        repeat (2) @(posedge clk);
        #1 WRST = 1'b0;
        wait_done("t4a");
        push(8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8, 4, 3);
        start(3'd7, 4'b0000, 4'b1111);
        @(negedge clk);
        chk("b2b_busy", BUSY, 1'b1);
        wait_done("t4b");
        @(posedge clk); #1;

        // Asynchronous reset during WRITE
        start(3'd3, 4'b0000, 4'b0000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wrcur", WRCUR, 8'h00);
        chk("arst_id", {ID6, ID9, ID12, ID14}, 32'h0);
        chk("arst_busy", BUSY, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw |= WDONE;
        end
        chk("arst_no_wdone", saw, 1'b0);
        @(posedge clk); #1;
        push(8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8, 4, 3);
        start(3'd4, 4'b0011, 4'b1111);
        wait_done("t5");
        @(posedge clk); #1;

        // Minimum-timing instance: one cycle per phase
        MSEL = 3'd6; {BRA6, BRA9, BRA12, BRA14} = 4'b1100; WRST_F = 1'b1;
        @(posedge clk); #1 WRST_F = 1'b0;
        @(negedge clk);
        chk("fast_c1_busy_wrcur", {F_BUSY, F_WRCUR}, {1'b1, 8'h00});
        chk("fast_c1_id", {F_ID6, F_ID9, F_ID12, F_ID14}, {8'h00, 8'h00, 8'h40, 8'h40});
        @(negedge clk);
        chk("fast_c2_wrcur", F_WRCUR, 8'h40);
        @(negedge clk);
        chk("fast_c3", {F_BUSY, F_WRCUR, F_ID14}, {1'b1, 8'h00, 8'h40});
        @(negedge clk);
        chk("fast_c4", {F_BUSY, F_WDONE, F_ID12}, {1'b0, 1'b1, 8'h00});
        @(negedge clk);
        chk("fast_c5_wdone", F_WDONE, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("idle_outputs_bad", idle_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
